// File: rtl/quad_decoder.sv
// == quad_decoder: x4 quadrature decoder with position, index, error and windowed speed ==
// == rev 1.0 ==
`default_nettype none

module quad_decoder #(
  parameter int POS_W     = 16,
  parameter int CPR       = 4096,
  parameter int SPD_W     = 16,
  parameter int SPEED_WIN = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cha_in,
  input  logic             chb_in,
  input  logic             chz_in,
  input  logic             pos_clr,
  input  logic             err_clr,
  output logic [POS_W-1:0] pos_out,
  output logic             dir_out,
  output logic             idx_pulse,
  output logic             index_seen,
  output logic             err_out,
  output logic [SPD_W-1:0] speed_out,
  output logic             speed_valid
);

  localparam int                      WIN_W    = $clog2(SPEED_WIN);
  localparam logic [WIN_W-1:0]        WIN_LAST = WIN_W'(SPEED_WIN - 1);
  localparam logic [POS_W-1:0]        POS_MAX  = POS_W'(CPR - 1);
  localparam logic signed [SPD_W:0]   SAT_HI   = (SPD_W+1)'((2 ** (SPD_W - 1)) - 1);
  localparam logic signed [SPD_W:0]   SAT_LO   = -SAT_HI;

  logic [1:0]             ab_s, ab_p;
  logic                   z_s, z_p;
  logic [WIN_W-1:0]       win_cnt;
  logic signed [SPD_W-1:0] acc;

  logic [1:0]             delta;
  logic                   step_fwd, step_rev, step_bad, idx_ev;
  logic signed [1:0]      step;
  logic signed [SPD_W:0]  sum;
  logic signed [SPD_W:0]  sum_sat;

  // Gray phase number along the forward sequence 00->10->11->01
  function automatic logic [1:0] phase(input logic [1:0] ab);
    case (ab)
      2'b00:   phase = 2'd0;
      2'b10:   phase = 2'd1;
      2'b11:   phase = 2'd2;
      default: phase = 2'd3;
    endcase
  endfunction

  always_comb begin
    delta    = phase(ab_s) - phase(ab_p);
    step_fwd = (delta == 2'd1);
    step_rev = (delta == 2'd3);
    step_bad = (delta == 2'd2);
    idx_ev   = z_s & ~z_p;
    step     = step_fwd ? 2'sb01 : (step_rev ? 2'sb11 : 2'sb00);
    sum      = {acc[SPD_W-1], acc} + {{(SPD_W-1){step[1]}}, step};
    sum_sat  = sum;
    if (sum > SAT_HI) begin
      sum_sat = SAT_HI;
    end else if (sum < SAT_LO) begin
      sum_sat = SAT_LO;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Both input stages load the live inputs so release cannot fake a step or index
      ab_s        <= {cha_in, chb_in};
      ab_p        <= {cha_in, chb_in};
      z_s         <= chz_in;
      z_p         <= chz_in;
      pos_out     <= '0;
      dir_out     <= 1'b0;
      idx_pulse   <= 1'b0;
      index_seen  <= 1'b0;
      err_out     <= 1'b0;
      speed_out   <= '0;
      speed_valid <= 1'b0;
      win_cnt     <= '0;
      acc         <= '0;
    end else begin
      ab_s      <= {cha_in, chb_in};
      ab_p      <= ab_s;
      z_s       <= chz_in;
      z_p       <= z_s;
      idx_pulse <= idx_ev;

      if (idx_ev) begin
        index_seen <= 1'b1;
      end

      if (pos_clr || idx_ev) begin
        pos_out <= '0;
      end else if (step_fwd) begin
        pos_out <= (pos_out == POS_MAX) ? '0 : pos_out + 1'b1;
      end else if (step_rev) begin
        pos_out <= (pos_out == '0) ? POS_MAX : pos_out - 1'b1;
      end

      if (step_fwd) begin
        dir_out <= 1'b1;
      end else if (step_rev) begin
        dir_out <= 1'b0;
      end

      if (step_bad) begin
        err_out <= 1'b1;
      end else if (err_clr) begin
        err_out <= 1'b0;
      end

      if (win_cnt == WIN_LAST) begin
        win_cnt     <= '0;
        speed_out   <= sum_sat[SPD_W-1:0];
        acc         <= '0;
        speed_valid <= 1'b1;
      end else begin
        win_cnt     <= win_cnt + 1'b1;
        acc         <= sum_sat[SPD_W-1:0];
        speed_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
